// File: rtl/decoder_seq.sv
// Registered one-hot decoder with a static-pattern mode and a walking-one mode.
// The walking-one mode rotates at a programmable rate and pulses STEP on each rotation.
module decoder_seq #(
  parameter int                SEL_W   = 3,
  parameter int                OUT_W   = 2**SEL_W,
  parameter logic [OUT_W-1:0]  PATTERN = 8'b11001100,
  parameter int                DIV_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              E,
  input  logic              A,
  input  logic              B,
  input  logic [SEL_W-1:0]  S,
  input  logic [DIV_W-1:0]  RATE,
  output logic [OUT_W-1:0]  D,
  output logic              VALID,
  output logic              STEP
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_PAT  = 2'b01,
    MODE_DEC  = 2'b10,
    MODE_WALK = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [OUT_W-1:0]   r_d;
  logic [OUT_W-1:0]   w_d_nxt;
  logic [DIV_W-1:0]   r_cnt;
  logic [DIV_W-1:0]   w_cnt_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_step;
  logic               w_step_nxt;
  mode_e              w_mode;

  // A disabled block behaves exactly like mode 00, whatever A and B say.
  assign w_mode = E ? mode_e'({A, B}) : MODE_OFF;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_d     <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = (w_mode == MODE_WALK) ? ST_RUN : ST_IDLE;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    w_d_nxt     = '0;
    w_cnt_nxt   = '0;
    w_valid_nxt = 1'b0;
    w_step_nxt  = 1'b0;
    unique case (w_mode)
      MODE_DEC: begin
        w_d_nxt     = OUT_W'(1) << S;
        w_valid_nxt = 1'b1;
      end
      MODE_PAT: begin
        w_d_nxt     = PATTERN;
        w_valid_nxt = 1'b1;
      end
      MODE_WALK: begin
        w_valid_nxt = 1'b1;
        if (r_state == ST_IDLE) begin
          // Entry: S is only consumed here, later S changes are ignored.
          w_d_nxt = OUT_W'(1) << S;
        end else if (r_cnt >= RATE) begin
          // >= rather than == so a RATE lowered below cnt rotates at once.
          w_d_nxt    = {r_d[OUT_W-2:0], r_d[OUT_W-1]};
          w_step_nxt = 1'b1;
        end else begin
          w_d_nxt   = r_d;
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      default: begin
        w_d_nxt = '0;
      end
    endcase
  end

  assign D     = r_d;
  assign VALID = r_valid;
  assign STEP  = r_step;

endmodule
